mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: DATA_W, 32, data width.
REQ-003 Parameter: TIMEOUT, 15, max BUSY cycles without mem_ack before abort (range 1..255).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 mN_req  in  1  requester N (N=0,1) access request; held until mN_gnt.
REQ-007 mN_we  in  1  requester N write enable (1=write, 0=read).
REQ-008 mN_addr  in  ADDR_W  requester N byte address.
REQ-009 mN_wdata  in  DATA_W  requester N write data.
REQ-010 mN_gnt  out  1  one-cycle grant pulse; request fields latched.
REQ-011 mN_rvalid  out  1  one-cycle completion pulse (reads and writes).
REQ-012 mN_rdata  out  DATA_W  read data, valid with mN_rvalid.
REQ-013 mN_err  out  1  timeout flag, valid with mN_rvalid.
REQ-014 mem_en  out  1  memory access active; held until ack or abort.
REQ-015 mem_we, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  latched request fields.
REQ-016 mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
REQ-017 mem_ack  in  1  memory completion, variable latency >= 1 cycle after mem_en rises.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 FSM SHALL have states IDLE and BUSY only.
REQ-020 IDLE, any mN_req=1 at edge: select winner, latch we/addr/wdata, next cycle mN_gnt=1 (one cycle), mem_en=1, state BUSY.
REQ-021 Arbitration: single requester wins; both requesting -> requester not granted last (last_gnt), then last_gnt updates to winner.
REQ-022 IDLE with no request: outputs idle, last_gnt unchanged.
REQ-023 BUSY: mem_en, mem_we, mem_addr, mem_wdata held stable; requests ignored; no gnt issued.
REQ-024 BUSY, mem_ack=1 at edge: next cycle mem_en=0, owner rvalid=1, rdata=mem_rdata (0 for writes), err=0, state IDLE.
REQ-025 Busy counter: 1 on first BUSY cycle, +1 each BUSY cycle without ack; saturating width 8 bits.
REQ-026 Counter==TIMEOUT and mem_ack=0 at edge: next cycle mem_en=0, owner rvalid=1, err=1, rdata=0, state IDLE.
REQ-027 Counter==TIMEOUT with mem_ack=1: ack wins, normal completion, err=0.
REQ-028 mem_ack in IDLE SHALL be ignored (no rvalid, no state change).
REQ-029 Non-owner rvalid/err/gnt SHALL stay 0; rdata of non-owner holds last value.
REQ-030 Latency: req sampled cycle 0 -> gnt cycle 1; ack sampled cycle k -> rvalid cycle k+1; next grant earliest cycle k+2.
REQ-031 Request dropped before sampled in IDLE SHALL not be granted.

Reset
REQ-032 reset=0 SHALL immediately, without clk: state IDLE, counter 0, last_gnt=1 (m0 wins first tie), all outputs 0.
REQ-033 Reset during BUSY SHALL abandon the transaction: no rvalid, no err issued afterward.
REQ-034 First IDLE evaluation SHALL occur on the first rising edge after reset returns to 1.

Verification
REQ-035 m0 write addr=100 wdata=25, ack 2 cycles after mem_en -> m0_gnt cycle 1, mem_addr=100, mem_wdata=25, mem_we=1, m0_rvalid=1 err=0 cycle 4.
REQ-036 m0 and m1 both reading from reset, ack immediately -> grant order m0, m1, m0, m1; each rvalid to correct owner only.
REQ-037 m1 read addr=96, mem_rdata=7 with ack -> m1_rdata=7, m1_rvalid one cycle, m0 outputs unchanged.
REQ-038 TIMEOUT=4, no ack -> mem_en high exactly 4 cycles, then m0_rvalid=1, m0_err=1, m0_rdata=0; ack at counter 4 instead -> err=0.
REQ-039 reset=0 asynchronously mid-BUSY -> all outputs 0 same instant; after release, no stale rvalid; next tie grants m0.
REQ-040 mem_ack pulsed in IDLE with no requests -> no rvalid, mem_en stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter. Round-robin on simultaneous requests, a single
// outstanding memory access, and a per-access busy timeout that aborts the
// access and reports an error to its owner. Every output is driven by a flop.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_gnt_q, last_gnt_d;  // index of the most recent winner
    logic       owner_q, owner_d;        // index of the requester owning the access

    logic              m0_gnt_q, m0_gnt_d;
    logic              m1_gnt_q, m1_gnt_d;
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              m0_err_q, m0_err_d;
    logic              m1_err_q, m1_err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              any_req;
    logic              winner;
    logic              timeout_hit;
    logic              done;
    logic [DATA_W-1:0] cpl_rdata;

    assign any_req     = m0_req | m1_req;
    // On a tie the requester that did not win last time goes first.
    assign winner      = (m0_req & m1_req) ? ~last_gnt_q : m1_req;
    assign timeout_hit = (cnt_q == TimeoutCnt);
    // An ack on the timeout cycle still counts as a normal completion.
    assign done        = mem_ack | timeout_hit;
    // Writes and aborted accesses return zero data.
    assign cpl_rdata   = (mem_ack && !mem_we_q) ? mem_rdata : '0;

    // State register: FSM state, busy counter, arbitration history, owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
        end
    end

    // Next-state logic: grant from IDLE, complete or abort from BUSY.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d    = StBusy;
                    cnt_d      = 8'd1;
                    last_gnt_d = winner;
                    owner_d    = winner;
                end
            end
            StBusy: begin
                if (done) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: next values of the registered grant, completion and memory outputs.
    always_comb begin
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_err_d    = 1'b0;
        m1_err_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    mem_en_d = 1'b1;
                    if (winner) begin
                        m1_gnt_d    = 1'b1;
                        mem_we_d    = m1_we;
                        mem_addr_d  = m1_addr;
                        mem_wdata_d = m1_wdata;
                    end else begin
                        m0_gnt_d    = 1'b1;
                        mem_we_d    = m0_we;
                        mem_addr_d  = m0_addr;
                        mem_wdata_d = m0_wdata;
                    end
                end
            end
            StBusy: begin
                if (done) begin
                    mem_en_d = 1'b0;
                    if (owner_q) begin
                        m1_rvalid_d = 1'b1;
                        m1_err_d    = ~mem_ack;
                        m1_rdata_d  = cpl_rdata;
                    end else begin
                        m0_rvalid_d = 1'b1;
                        m0_err_d    = ~mem_ack;
                        m0_rdata_d  = cpl_rdata;
                    end
                end
            end
            default: mem_en_d = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_err_q    <= m0_err_d;
            m1_err_q    <= m1_err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_err    = m0_err_q;
    assign m1_err    = m1_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus predicts grant order and completion
// results into queues, a memory responder plays out the planned ack latencies,
// and a monitor pops and compares whenever the DUT grants or completes.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk;
    logic          reset;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          mem_en, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata (m0_rdata),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata (m1_rdata),
        .m1_err   (m1_err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    typedef struct {
        logic          who;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct {
        logic          who;
        logic [DW-1:0] rdata;
        logic          err;
        int            dur;
    } rsp_t;

    typedef struct {
        int            lat;   // busy cycle on which ack is given, 0 = never
        logic [DW-1:0] rdata;
    } plan_t;

    gnt_t  gnt_q[$];
    rsp_t  rsp_q[$];
    plan_t plan_q[$];

    int   total = 0;
    int   bad = 0;
    int   rvalid_seen = 0;
    bit   stray_all = 0;
    logic last_win;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: one access at a time, tie goes to whoever did not win last,
    // timeout after TO busy cycles returns err with zero data.
    task automatic push_txn(input logic who, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int lat, input logic [DW-1:0] rd);
        gnt_t  g;
        rsp_t  r;
        plan_t p;
        g = '{who, we, a, d};
        p = '{lat, rd};
        r.who   = who;
        r.err   = (lat == 0);
        r.rdata = (we || lat == 0) ? '0 : rd;
        r.dur   = (lat == 0) ? int'(TO) : lat;
        gnt_q.push_back(g);
        plan_q.push_back(p);
        rsp_q.push_back(r);
        last_win = who;
    endtask

    task automatic issue_round(input logic [1:0] pat,
                               input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input int lat0, input logic [DW-1:0] r0,
                               input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input int lat1, input logic [DW-1:0] r1);
        logic first;
        int   cyc;
        first = (pat == 2'b11) ? ~last_win : pat[1];
        if (first) push_txn(1'b1, we1, a1, d1, lat1, r1);
        else       push_txn(1'b0, we0, a0, d0, lat0, r0);
        if (pat == 2'b11) begin
            if (first) push_txn(1'b0, we0, a0, d0, lat0, r0);
            else       push_txn(1'b1, we1, a1, d1, lat1, r1);
        end
        @(negedge clk);
        m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_we = we1; m1_addr = a1; m1_wdata = d1;
        m0_req = pat[0];
        m1_req = pat[1];
        @(negedge clk);
        check("gnt_latency", 64'(first ? m1_gnt : m0_gnt), 64'(1));
        cyc = 0;
        while ((m0_req || m1_req || rsp_q.size() != 0) && cyc < 80) begin
            if (m0_gnt) m0_req = 1'b0;
            if (m1_gnt) m1_req = 1'b0;
            if (m0_req || m1_req || rsp_q.size() != 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("round_completes", 64'(cyc < 80), 64'(1));
        if (cyc >= 80) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
            gnt_q.delete();
            rsp_q.delete();
            plan_q.delete();
            repeat (10) @(negedge clk);
        end
    endtask

    // Memory responder: plays the planned ack latency for each access and
    // scatters ignored acks while idle.
    initial begin : responder
        int    n;
        bit    have;
        bit    prev_en;
        plan_t cur;
        n = 0; have = 0; prev_en = 0;
        cur = '{0, '0};
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (!prev_en) begin
                    n = 1;
                    have = (plan_q.size() != 0);
                    if (have) cur = plan_q.pop_front();
                end else begin
                    n++;
                end
                if (have && cur.lat == n) begin
                    mem_ack = 1'b1;
                    mem_rdata = cur.rdata;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                n = 0;
                mem_ack = stray_all ? ~mem_ack : ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
            prev_en = mem_en;
        end
    end

    // Monitor: pops expectations on every grant and completion.
    initial begin : monitor
        gnt_t          g;
        rsp_t          r;
        logic [DW-1:0] hold0, hold1;
        int            en_cnt;
        bit            busy;
        hold0 = '0; hold1 = '0; en_cnt = 0; busy = 0;
        g = '{1'b0, 1'b0, '0, '0};
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold0 = '0; hold1 = '0; en_cnt = 0; busy = 0;
            end else begin
                if (m0_gnt || m1_gnt) begin
                    check("gnt_exclusive", 64'(m0_gnt & m1_gnt), 64'(0));
                    check("gnt_expected", 64'(gnt_q.size() != 0), 64'(1));
                    if (gnt_q.size() != 0) begin
                        g = gnt_q.pop_front();
                        check("gnt_owner", 64'(m1_gnt), 64'(g.who));
                        check("gnt_mem_en", 64'(mem_en), 64'(1));
                        check("gnt_mem_we", 64'(mem_we), 64'(g.we));
                        check("gnt_mem_addr", 64'(mem_addr), 64'(g.addr));
                        check("gnt_mem_wdata", 64'(mem_wdata), 64'(g.wdata));
                        busy = 1;
                    end
                    en_cnt = 0;
                end
                if (mem_en) begin
                    en_cnt++;
                    if (busy) begin
                        check("busy_fields_stable", {mem_we, mem_addr, mem_wdata[30:0]},
                              {g.we, g.addr, g.wdata[30:0]});
                    end
                end
                if (m0_rvalid || m1_rvalid) begin
                    rvalid_seen++;
                    check("rvalid_exclusive", 64'(m0_rvalid & m1_rvalid), 64'(0));
                    check("rvalid_expected", 64'(rsp_q.size() != 0), 64'(1));
                    if (rsp_q.size() != 0) begin
                        r = rsp_q.pop_front();
                        check("rvalid_owner", 64'(m1_rvalid), 64'(r.who));
                        check("cpl_mem_en_low", 64'(mem_en), 64'(0));
                        check("mem_en_cycles", 64'(en_cnt), 64'(r.dur));
                        if (r.who) begin
                            check("m1_rdata", 64'(m1_rdata), 64'(r.rdata));
                            check("m1_err", 64'(m1_err), 64'(r.err));
                            check("m0_rdata_hold", 64'(m0_rdata), 64'(hold0));
                            check("m0_err_idle", 64'(m0_err), 64'(0));
                            hold1 = r.rdata;
                        end else begin
                            check("m0_rdata", 64'(m0_rdata), 64'(r.rdata));
                            check("m0_err", 64'(m0_err), 64'(r.err));
                            check("m1_rdata_hold", 64'(m1_rdata), 64'(hold1));
                            check("m1_err_idle", 64'(m1_err), 64'(0));
                            hold0 = r.rdata;
                        end
                    end
                    busy = 0;
                    en_cnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int seen;
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        last_win = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("reset_outputs",
              64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_en, mem_we,
                   |m0_rdata, |m1_rdata, |mem_addr, |mem_wdata}), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Both reading from reset, ack on the first busy cycle: m0, m1, m0, m1.
        issue_round(2'b11, 1'b0, 32'h10, 32'h0, 1, 32'hA0A0_0001,
                           1'b0, 32'h20, 32'h0, 1, 32'hB0B0_0002);
        issue_round(2'b11, 1'b0, 32'h14, 32'h0, 1, 32'hA0A0_0003,
                           1'b0, 32'h24, 32'h0, 1, 32'hB0B0_0004);
        // m0 write addr 100 data 25, ack two cycles after mem_en rises.
        issue_round(2'b01, 1'b1, 32'd100, 32'd25, 3, 32'hDEAD_BEEF,
                           1'b0, 32'h0, 32'h0, 1, 32'h0);
        // m1 read addr 96 returning 7, m0 outputs must not move.
        issue_round(2'b10, 1'b0, 32'h0, 32'h0, 1, 32'h0,
                           1'b0, 32'd96, 32'h0, 2, 32'd7);
        // Timeout with no ack, then ack on exactly the timeout cycle.
        issue_round(2'b01, 1'b0, 32'h40, 32'h0, 0, 32'h1234_5678,
                           1'b0, 32'h0, 32'h0, 1, 32'h0);
        issue_round(2'b01, 1'b0, 32'h44, 32'h0, int'(TO), 32'h0000_0055,
                           1'b0, 32'h0, 32'h0, 1, 32'h0);

        // A request pulse that never straddles a rising edge is not granted.
        @(negedge clk);
        #1 m1_req = 1'b1;
        #2 m1_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("glitch_no_gnt", 64'({m0_gnt, m1_gnt, mem_en}), 64'(0));
        end

        // Acks while idle are ignored.
        seen = rvalid_seen;
        stray_all = 1;
        repeat (6) begin
            @(negedge clk);
            check("idle_ack_mem_en", 64'(mem_en), 64'(0));
        end
        stray_all = 0;
        check("idle_ack_no_rvalid", 64'(rvalid_seen - seen), 64'(0));

        // Asynchronous reset in the middle of a busy access.
        push_txn(1'b1, 1'b0, 32'h80, 32'h0, 0, 32'h0);
        void'(rsp_q.pop_back());
        @(negedge clk);
        m1_we = 1'b0; m1_addr = 32'h80;
        m1_req = 1'b1;
        @(negedge clk);
        check("midbusy_gnt", 64'(m1_gnt), 64'(1));
        m1_req = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_en, mem_we,
                   |m0_rdata, |m1_rdata, |mem_addr, |mem_wdata}), 64'(0));
        gnt_q.delete();
        rsp_q.delete();
        plan_q.delete();
        last_win = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = rvalid_seen;
        repeat (8) @(negedge clk);
        check("no_stale_rvalid", 64'(rvalid_seen - seen), 64'(0));
        check("post_reset_idle", 64'(mem_en), 64'(0));
        issue_round(2'b11, 1'b0, 32'h200, 32'h0, 2, 32'h0000_0AAA,
                           1'b1, 32'h204, 32'h77, 1, 32'h0);

        // Randomized rounds.
        for (int i = 0; i < 200; i++) begin
            logic [1:0] pat;
            pat = 2'($urandom_range(1, 3));
            issue_round(pat, 1'($urandom_range(0, 1)), $urandom, $urandom,
                        int'($urandom_range(0, TO)), $urandom,
                        1'($urandom_range(0, 1)), $urandom, $urandom,
                        int'($urandom_range(0, TO)), $urandom);
        end

        repeat (4) @(negedge clk);
        check("final_queues_empty", 64'(gnt_q.size() + rsp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
